// File: rtl/csr_pkg.sv
// csr_pkg: shared types and constants for the CSR read-modify-write unit.
//   fu_op_t      - functional-unit operator; CSR ops use their funct3 encodings,
//                  the two remaining codes stand for non-CSR operators.
//   csr_state_e  - sequencing states of csr_rmw_unit.
//   CSR_RO_PREFIX, ILL_INSTR - read-only address prefix and illegal-instruction cause.
package csr_pkg;

  typedef enum logic [2:0] {
    FU_NONE  = 3'b000,
    CSRRW    = 3'b001,
    CSRRS    = 3'b010,
    CSRRC    = 3'b011,
    FU_OTHER = 3'b100,
    CSRRWI   = 3'b101,
    CSRRSI   = 3'b110,
    CSRRCI   = 3'b111
  } fu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR,
    WB,
    DRAIN
  } csr_state_e;

  localparam logic [1:0]  CSR_RO_PREFIX = 2'b11;
  localparam int unsigned ILL_INSTR     = 2;

  // funct3[1:0] == 0 is not a CSR operation.
  function automatic logic is_csr_op(input fu_op_t op);
    return op[1:0] != 2'b00;
  endfunction

  // funct3[2] selects the zimm (immediate) forms.
  function automatic logic is_imm_op(input fu_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rw_op(input fu_op_t op);
    return op[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/csr_alu.sv
// csr_alu: combinational new-value computation and side-effect qualifiers.
//   op_i       - CSR operator
//   operand_i  - rs1 value or zero-extended zimm
//   old_i      - current CSR value
//   rs1_idx_i  - rs1 index / zimm (zero suppresses the write for set/clear forms)
//   rd_idx_i   - destination index (x0 suppresses the read for write forms)
//   new_o      - value to write back
//   wr_en_o    - write side effect required
//   rd_en_o    - read side effect required
module csr_alu
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  fu_op_t          op_i,
  input  logic [XLEN-1:0] operand_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [4:0]      rs1_idx_i,
  input  logic [4:0]      rd_idx_i,
  output logic [XLEN-1:0] new_o,
  output logic            wr_en_o,
  output logic            rd_en_o
);

  always_comb begin
    new_o = old_i;
    unique case (op_i[1:0])
      2'b01:   new_o = operand_i;
      2'b10:   new_o = old_i | operand_i;
      2'b11:   new_o = old_i & ~operand_i;
      default: new_o = old_i;
    endcase
  end

  assign wr_en_o = is_rw_op(op_i) || (rs1_idx_i != 5'd0);
  assign rd_en_o = !is_rw_op(op_i) || (rd_idx_i != 5'd0);

endmodule

// File: rtl/csr_rmw_unit.sv
// csr_rmw_unit: multi-cycle Zicsr execute unit between issue and the CSR file.
//   clk_i, rst_ni                 - clock, async active-low reset
//   valid_i / ready_o             - op handshake (ready only in IDLE)
//   operator_i, csr_addr_i,
//   rs1_data_i, rs1_idx_i, rd_idx_i - op fields
//   flush_i                       - pipeline kill
//   csr_addr_o, csr_read_o        - CSR file read request
//   csr_rvalid_i, csr_rerr_i,
//   csr_rdata_i                   - CSR file read response
//   csr_write_o, csr_wdata_o      - CSR file write strobe
//   wb_valid_o, wb_data_o,
//   ex_valid_o, ex_cause_o        - completion and exception
//
// state   | meaning
// IDLE    | ready for a new op
// RD_REQ  | read request pulse on csr_read_o
// RD_WAIT | waiting for csr_rvalid_i
// WR      | write strobe slot (strobe only if the op writes)
// WB      | completion pulse on wb_valid_o
// DRAIN   | flushed with a read outstanding; swallow its response
module csr_rmw_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CSR_AW    = 12,
  parameter int unsigned ILL_CAUSE = ILL_INSTR
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  fu_op_t            operator_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [4:0]        rs1_idx_i,
  input  logic [4:0]        rd_idx_i,
  input  logic              flush_i,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic              csr_read_o,
  input  logic              csr_rvalid_i,
  input  logic              csr_rerr_i,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic              csr_write_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              wb_valid_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_cause_o
);

  csr_state_e        state_q, state_d;
  fu_op_t            op_q, op_d, alu_op;
  logic [XLEN-1:0]   operand_q, operand_d, operand_in;
  logic [XLEN-1:0]   old_q, old_d;
  logic              wr_en_q, wr_en_d;
  logic [CSR_AW-1:0] addr_q, addr_d;
  logic              ready_q, ready_d, read_q, read_d, write_q, write_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, wb_data_q, wb_data_d, ex_cause_q, ex_cause_d;
  logic              wb_valid_q, wb_valid_d, ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]   alu_new;
  logic              alu_wr_en, alu_rd_en;

  assign operand_in = is_imm_op(operator_i) ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_data_i;

  // In IDLE the ALU qualifies the incoming op; afterwards it computes the new value.
  assign alu_op = (state_q == IDLE) ? operator_i : op_q;

  csr_alu #(.XLEN(XLEN)) u_alu (
    .op_i      (alu_op),
    .operand_i (operand_q),
    .old_i     (csr_rdata_i),
    .rs1_idx_i (rs1_idx_i),
    .rd_idx_i  (rd_idx_i),
    .new_o     (alu_new),
    .wr_en_o   (alu_wr_en),
    .rd_en_o   (alu_rd_en)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    operand_d  = operand_q;
    old_d      = old_q;
    wr_en_d    = wr_en_q;
    addr_d     = addr_q;
    read_d     = 1'b0;
    write_d    = 1'b0;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_data_d  = '0;
    ex_valid_d = 1'b0;
    ex_cause_d = '0;
    unique case (state_q)
      IDLE: begin
        if (!flush_i && valid_i && is_csr_op(operator_i)) begin
          op_d      = operator_i;
          operand_d = operand_in;
          old_d     = '0;
          wr_en_d   = alu_wr_en;
          addr_d    = csr_addr_i;
          if (alu_wr_en && (csr_addr_i[11:10] == CSR_RO_PREFIX)) begin
            state_d    = WB;
            wb_valid_d = 1'b1;
            ex_valid_d = 1'b1;
            ex_cause_d = XLEN'(ILL_CAUSE);
          end else if (!alu_rd_en) begin
            // Only RW forms skip the read, so the new value is the operand itself.
            state_d = WR;
            write_d = 1'b1;
            wdata_d = operand_in;
          end else begin
            state_d = RD_REQ;
            read_d  = 1'b1;
          end
        end
      end
      RD_REQ: state_d = flush_i ? DRAIN : RD_WAIT;
      RD_WAIT: begin
        if (csr_rvalid_i) begin
          // A flush coinciding with the response has nothing left to drain.
          if (flush_i) begin
            state_d = IDLE;
          end else if (csr_rerr_i) begin
            state_d    = WB;
            wb_valid_d = 1'b1;
            ex_valid_d = 1'b1;
            ex_cause_d = XLEN'(ILL_CAUSE);
          end else begin
            state_d = WR;
            old_d   = csr_rdata_i;
            write_d = wr_en_q;
            if (wr_en_q) wdata_d = alu_new;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      WR: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          state_d    = WB;
          wb_valid_d = 1'b1;
          wb_data_d  = old_q;
        end
      end
      WB:      state_d = IDLE;
      DRAIN:   if (csr_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_q       <= FU_NONE;
      operand_q  <= '0;
      old_q      <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      ready_q    <= 1'b1;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_cause_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      operand_q  <= operand_d;
      old_q      <= old_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      ready_q    <= ready_d;
      read_q     <= read_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      ex_valid_q <= ex_valid_d;
      ex_cause_q <= ex_cause_d;
    end
  end

  assign ready_o     = ready_q;
  assign csr_addr_o  = addr_q;
  assign csr_read_o  = read_q;
  assign csr_write_o = write_q;
  assign csr_wdata_o = wdata_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_data_o   = wb_data_q;
  assign ex_valid_o  = ex_valid_q;
  assign ex_cause_o  = ex_cause_q;

endmodule

// File: tb/tb_csr_rmw_unit.sv
// tb_csr_rmw_unit: scoreboard bench for csr_rmw_unit with a behavioural CSR file
// that answers each read after a programmable latency.
module tb_csr_rmw_unit;
  import csr_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  fu_op_t      operator_i;
  logic [11:0] csr_addr_i;
  logic [31:0] rs1_data_i;
  logic [4:0]  rs1_idx_i;
  logic [4:0]  rd_idx_i;
  logic        flush_i;
  logic [11:0] csr_addr_o;
  logic        csr_read_o;
  logic        csr_rvalid_i;
  logic        csr_rerr_i;
  logic [31:0] csr_rdata_i;
  logic        csr_write_o;
  logic [31:0] csr_wdata_o;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic        ex_valid_o;
  logic [31:0] ex_cause_o;

  csr_rmw_unit #(.XLEN(32), .CSR_AW(12), .ILL_CAUSE(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .csr_addr_i(csr_addr_i), .rs1_data_i(rs1_data_i),
    .rs1_idx_i(rs1_idx_i), .rd_idx_i(rd_idx_i), .flush_i(flush_i),
    .csr_addr_o(csr_addr_o), .csr_read_o(csr_read_o), .csr_rvalid_i(csr_rvalid_i),
    .csr_rerr_i(csr_rerr_i), .csr_rdata_i(csr_rdata_i), .csr_write_o(csr_write_o),
    .csr_wdata_o(csr_wdata_o), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
    .ex_valid_o(ex_valid_o), .ex_cause_o(ex_cause_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] wb_data;
    bit          ex;
    int          wb_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] wq[$];

  int n_chk = 0, n_pass = 0;
  int n_reads = 0, n_writes = 0, n_wb = 0;
  int rd_lat = 1, rsp_cnt = 0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic [11:0] exp_addr = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  // CSR file responder and output monitor, both sampling at the falling edge.
  initial begin
    exp_t e;
    csr_rvalid_i = 1'b0;
    csr_rerr_i   = 1'b0;
    csr_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      csr_rvalid_i = 1'b0;
      csr_rerr_i   = 1'b0;
      csr_rdata_i  = '0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          csr_rvalid_i = 1'b1;
          csr_rdata_i  = rsp_data;
          csr_rerr_i   = rsp_err;
        end
      end
      if (csr_read_o) begin
        n_reads++;
        rsp_cnt = rd_lat;
        chk("rd_addr", 64'(csr_addr_o), 64'(exp_addr));
      end
      if (csr_write_o) begin
        n_writes++;
        if (wq.size() == 0) chk("write_unexpected", 64'(csr_write_o), 64'd0);
        else chk("wdata", 64'(csr_wdata_o), 64'(wq.pop_front()));
      end
      if (wb_valid_o) begin
        n_wb++;
        if (sb.size() == 0) chk("wb_unexpected", 64'(wb_valid_o), 64'd0);
        else begin
          e = sb.pop_front();
          chk("wb_data", 64'(wb_data_o), 64'(e.wb_data));
          chk("ex_valid", 64'(ex_valid_o), 64'(e.ex));
          chk("ex_cause", 64'(ex_cause_o), e.ex ? 64'd2 : 64'd0);
          chk("wb_cycle", 64'(cyc), 64'(e.wb_cyc));
        end
      end
    end
  end

  // Drive one op when ready; lat is cycles from the valid cycle to the wb_valid cycle.
  task automatic issue(input fu_op_t op, input logic [11:0] addr, input logic [31:0] rs1,
                       input logic [4:0] rs1_idx, input logic [4:0] rd_idx, input bit push,
                       input logic [31:0] exp_wb, input bit exp_ex, input int lat,
                       input bit exp_wr, input logic [31:0] exp_wdata, output int acc);
    exp_t e;
    int t = 0;
    @(negedge clk_i);
    while (!ready_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    if (!ready_o) chk("ready_timeout", 64'(ready_o), 64'd1);
    operator_i = op;
    csr_addr_i = addr;
    rs1_data_i = rs1;
    rs1_idx_i  = rs1_idx;
    rd_idx_i   = rd_idx;
    valid_i    = 1'b1;
    exp_addr   = addr;
    if (push) begin
      e.wb_data = exp_wb;
      e.ex      = exp_ex;
      e.wb_cyc  = cyc + lat;
      sb.push_back(e);
      if (exp_wr) wq.push_back(exp_wdata);
    end
    acc = cyc + 1;
    @(negedge clk_i);
    valid_i    = 1'b0;
    operator_i = FU_NONE;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk_i);
    while ((sb.size() != 0 || wq.size() != 0 || !ready_o || rsp_cnt != 0) && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    chk("idle_timeout", 64'(sb.size() + wq.size() + rsp_cnt), 64'd0);
  endtask

  initial begin
    int a, a2, r0, w0, b0;
    rst_ni = 1'b0; valid_i = 1'b0; operator_i = FU_NONE; csr_addr_i = '0;
    rs1_data_i = '0; rs1_idx_i = '0; rd_idx_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_outs", 64'({csr_read_o, csr_write_o, wb_valid_o, ex_valid_o}), 64'd0);
    chk("rst_data", 64'(csr_addr_o | csr_wdata_o | wb_data_o | ex_cause_o), 64'd0);
    rst_ni = 1'b1;

    // CSRRS read-modify-write
    rd_lat = 2; rsp_data = 32'h1800; rsp_err = 1'b0;
    r0 = n_reads;
    issue(CSRRS, 12'h300, 32'h8, 5'd5, 5'd1, 1, 32'h1800, 0, 5, 1, 32'h1808, a);
    wait_idle();
    chk("rs_reads", 64'(n_reads - r0), 64'd1);

    // CSRRC with rs1=x0: read only
    rd_lat = 1; rsp_data = 32'h0000_ABCD;
    r0 = n_reads; w0 = n_writes;
    issue(CSRRC, 12'h341, 32'hFFFF_FFFF, 5'd0, 5'd2, 1, 32'h0000_ABCD, 0, 4, 0, '0, a);
    wait_idle();
    chk("rc_x0_reads", 64'(n_reads - r0), 64'd1);
    chk("rc_x0_writes", 64'(n_writes - w0), 64'd0);

    // CSRRWI rd=x0: write only, zimm zero-extended
    r0 = n_reads;
    issue(CSRRWI, 12'h340, 32'hFFFF_FFFF, 5'd31, 5'd0, 1, 32'h0, 0, 2, 1, 32'h0000_001F, a);
    wait_idle();
    chk("rwi_reads", 64'(n_reads - r0), 64'd0);

    // CSRRW to read-only space: exception, no access
    r0 = n_reads; w0 = n_writes;
    issue(CSRRW, 12'hC00, 32'h1234, 5'd4, 5'd1, 1, 32'h0, 1, 1, 0, '0, a);
    wait_idle();
    chk("ro_access", 64'((n_reads - r0) + (n_writes - w0)), 64'd0);

    // CSRRS rs1=x0 on read-only CSR is a legal read
    rd_lat = 3; rsp_data = 32'h0000_0055;
    issue(CSRRS, 12'hC00, 32'h0, 5'd0, 5'd7, 1, 32'h55, 0, 6, 0, '0, a);
    wait_idle();

    // Register-form CSRRW with a read, CSRRCI / CSRRSI immediates
    rd_lat = 3; rsp_data = 32'h0000_1234;
    issue(CSRRW, 12'h305, 32'hDEAD_BEEF, 5'd9, 5'd3, 1, 32'h1234, 0, 6, 1, 32'hDEAD_BEEF, a);
    wait_idle();
    rd_lat = 1; rsp_data = 32'hFFFF_FFFF;
    issue(CSRRCI, 12'h300, 32'h0, 5'd17, 5'd4, 1, 32'hFFFF_FFFF, 0, 4, 1, 32'hFFFF_FFEE, a);
    wait_idle();
    rsp_data = 32'h8000_0000;
    issue(CSRRSI, 12'h300, 32'hFFFF_FFFF, 5'd31, 5'd4, 1, 32'h8000_0000, 0, 4, 1, 32'h8000_001F, a);
    wait_idle();

    // Read error: exception, no write
    rd_lat = 2; rsp_data = 32'hAAAA_5555; rsp_err = 1'b1;
    w0 = n_writes;
    issue(CSRRS, 12'h7FF, 32'h1, 5'd2, 5'd1, 1, 32'h0, 1, 4, 0, '0, a);
    wait_idle();
    chk("rerr_writes", 64'(n_writes - w0), 64'd0);
    rsp_err = 1'b0;

    // Non-CSR operator is dropped
    r0 = n_reads; b0 = n_wb;
    issue(FU_OTHER, 12'h300, 32'h1, 5'd1, 5'd1, 0, '0, 0, 0, 0, '0, a);
    repeat (4) @(negedge clk_i);
    chk("noncsr_ignored", 64'((n_reads - r0) + (n_wb - b0)), 64'd0);
    chk("noncsr_ready", 64'(ready_o), 64'd1);

    // Flush in IDLE suppresses accept
    r0 = n_reads; b0 = n_wb;
    @(negedge clk_i);
    operator_i = CSRRS; csr_addr_i = 12'h300; rs1_idx_i = 5'd1; rd_idx_i = 5'd1;
    valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("flush_idle_ignored", 64'((n_reads - r0) + (n_wb - b0)), 64'd0);

    // Flush in RD_WAIT: drain the late response, no write, no wb
    rd_lat = 4; rsp_data = 32'h0F0F_0F0F;
    r0 = n_reads; w0 = n_writes; b0 = n_wb;
    issue(CSRRW, 12'h301, 32'h5, 5'd3, 5'd1, 0, '0, 0, 0, 0, '0, a);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("drain_ready_0", 64'(ready_o), 64'd0);
    @(negedge clk_i);
    chk("drain_ready_1", 64'(ready_o), 64'd0);
    @(negedge clk_i);
    chk("drain_ready_2", 64'(ready_o), 64'd0);
    @(negedge clk_i);
    chk("drain_ready_3", 64'(ready_o), 64'd1);
    wait_idle();
    chk("flush_reads", 64'(n_reads - r0), 64'd1);
    chk("flush_no_wr_wb", 64'((n_writes - w0) + (n_wb - b0)), 64'd0);

    // Back-to-back write-only ops: next accept right after WB
    issue(CSRRWI, 12'h340, 32'h0, 5'd3, 5'd0, 1, 32'h0, 0, 2, 1, 32'h3, a);
    issue(CSRRWI, 12'h341, 32'h0, 5'd12, 5'd0, 1, 32'h0, 0, 2, 1, 32'hC, a2);
    chk("b2b_accept", 64'(a2), 64'(a + 3));
    wait_idle();

    // Async reset mid RD_WAIT
    rd_lat = 10; rsp_data = 32'h1;
    b0 = n_wb;
    issue(CSRRS, 12'h345, 32'h1, 5'd1, 5'd1, 0, '0, 0, 0, 0, '0, a);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_addr", 64'(csr_addr_o), 64'd0);
    chk("arst_outs", 64'({csr_read_o, csr_write_o, wb_valid_o, ex_valid_o}), 64'd0);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("arst_ready", 64'(ready_o), 64'd1);
    wait_idle();
    chk("arst_no_wb", 64'(n_wb - b0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
